multi_cycle_control: RTL
========================

# multi_cycle_control

Moore/Mealy control FSM for the multicycle CPU. It steps each instruction through IF/ID/EXE/MEM/WB states and drives every datapath control: PC, instruction register, register file, data memory, and the ALU's `ALUSrcB`/`ALUOp` inputs. The block sits between the instruction register and the datapath. It takes the opcode and the ALU `zero` flag and returns all select and write-enable lines.

## Interface
- No parameters. State encoding is fixed: sIF=000, sID=001, sEXE_LS=010, sMEM=011, sWB_LD=100, sEXE_BR=101, sEXE_AL=110, sWB_AL=111.
- `CLK` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low.
- `opcode` in 6: IR[31:26], stable from the cycle after IF.
- `zero` in 1: ALU zero flag.
- `PCWre` out 1: PC loads on the next edge.
- `PCSrc` out 2: 00 PC+4, 01 PC+4+(imm<<2), 10 rs (jr), 11 jump target.
- `InsMemRW` out 1: instruction memory read.
- `IRWre` out 1: IR load.
- `ExtSel` out 1: 0 zero-extend, 1 sign-extend.
- `ALUSrcA` out 1: 0 rs, 1 shamt.
- `ALUSrcB` out 1: 0 rt, 1 immediate.
- `ALUOp` out 3: 000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor (sets zero).
- `RegWre` out 1: register file write.
- `RegDst` out 2: 00 $31, 01 rt, 10 rd.
- `WrRegDSrc` out 1: 0 PC+4, 1 DB bus.
- `DBDataSrc` out 1: 0 ALU result, 1 memory.
- `mRD`, `mWR` out 1 each: data memory read and write.
- `state` out 3: current state, for debug.

## Operation
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt 111111
- Transitions:
  - sIF always goes to sID.
  - sID: j/jr/jal/illegal go to sIF; halt stays in sID; beq goes to sEXE_BR; lw/sw go to sEXE_LS; all others go to sEXE_AL.
  - sEXE_AL goes to sWB_AL, which goes to sIF.
  - sEXE_BR goes to sIF.
  - sEXE_LS goes to sMEM. sMEM goes to sWB_LD for lw and to sIF for sw. sWB_LD goes to sIF.
- Outputs are decoded combinationally from `state`, `opcode` and `zero`. Any signal not listed for a state is 0.
  - sIF: InsMemRW=1, IRWre=1.
  - sID:
    - ExtSel=0 for ori, 1 otherwise.
    - j: PCWre=1, PCSrc=11.
    - jr: PCWre=1, PCSrc=10.
    - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
    - illegal opcode: PCWre=1, PCSrc=00 (executes as a nop).
  - sEXE_AL: ALUOp per instruction (add/addi 000, sub 001, slt 010, sll 100, or/ori 101, and 110). ALUSrcA=1 for sll. ALUSrcB=1 for addi/ori.
  - sWB_AL:
    - ALU controls held at their sEXE_AL values.
    - RegWre=1, WrRegDSrc=1, DBDataSrc=0.
    - RegDst=01 for addi/ori, 10 otherwise.
    - PCWre=1, PCSrc=00.
  - sEXE_BR: ALUOp=111, ALUSrcB=0, PCWre=1, PCSrc = zero ? 01 : 00.
  - sEXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - sMEM: address controls held. lw asserts mRD=1. sw asserts mWR=1 with PCWre=1, PCSrc=00.
  - sWB_LD: mRD=1, RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1, PCSrc=00.
- Exactly one PCWre pulse per retired instruction. halt never asserts PCWre.

## Timing
- State register updates on the rising edge of `CLK`. `Reset` low forces sIF immediately, independent of `CLK`.
- Reset output values: state=000, InsMemRW=1, IRWre=1, all other outputs 0. These hold for as long as `Reset` is low.
- Reset asserted mid-instruction aborts it. Any pending RegWre/mWR/PCWre drops in the same cycle. After release, fetch restarts from sIF.
- Cycle counts per instruction:
  - j/jr/jal/illegal: 2.
  - beq: 3.
  - R-type/addi/ori: 4.
  - sw: 4.
  - lw: 5.
- `zero` is sampled only in sEXE_BR. It must settle within that cycle; no other state reacts to it.
- halt: the FSM stays in sID indefinitely with all write enables 0. Only `Reset` exits this condition.

## Test plan
- Reset: hold `Reset`=0 for 3 cycles → state=000, IRWre=1, InsMemRW=1, RegWre=0, PCWre=0, mWR=0. Release → state goes 001 on the next edge.
- add (000000): states 000,001,110,111,000. In sEXE_AL, ALUOp=000 and ALUSrcB=0. In sWB_AL, RegWre=1, RegDst=10 and PCWre=1.
- lw/sw: lw visits 000,001,010,011,100 with mRD=1 in sMEM/sWB_LD and a single PCWre in sWB_LD. sw takes 4 cycles with mWR=1 and PCWre=1 only in sMEM.
- beq: in sEXE_BR, zero=1 → ALUOp=111, PCSrc=01, PCWre=1. Repeat with zero=0 → PCSrc=00. Both return to sIF after 3 cycles.
- jal/halt: jal in sID → PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, then back to sIF. halt → state stays 001 for 10+ cycles with PCWre=0.
- Mid-operation reset: assert `Reset` in sMEM of sw → mWR and PCWre go to 0 asynchronously and state=000 before the next edge.

Source files
------------

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: control FSM for the multicycle CPU.
// Steps each instruction through IF/ID/EXE/MEM/WB and decodes every datapath
// control from the current state, the IR opcode and the ALU zero flag.
// Ports:
//   CLK, Reset (async, active-low)   clock / reset
//   opcode[5:0], zero                IR[31:26] and ALU zero flag
//   PCWre, PCSrc[1:0]                PC load enable and next-PC select
//   InsMemRW, IRWre                  instruction fetch / IR load
//   ExtSel, ALUSrcA, ALUSrcB, ALUOp  immediate extension and ALU controls
//   RegWre, RegDst[1:0], WrRegDSrc   register file write controls
//   DBDataSrc, mRD, mWR              write-back source and data memory
//   state[2:0]                       current state, for debug
module multi_cycle_control (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       InsMemRW,
  output logic       IRWre,
  output logic       ExtSel,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic [2:0] state
);

  localparam int unsigned OpW    = 6;
  localparam int unsigned StateW = 3;
  localparam int unsigned AluW   = 3;

  localparam logic [OpW-1:0] OpAdd  = 6'b000000;
  localparam logic [OpW-1:0] OpSub  = 6'b000001;
  localparam logic [OpW-1:0] OpAddi = 6'b000010;
  localparam logic [OpW-1:0] OpOr   = 6'b010000;
  localparam logic [OpW-1:0] OpAnd  = 6'b010001;
  localparam logic [OpW-1:0] OpOri  = 6'b010010;
  localparam logic [OpW-1:0] OpSll  = 6'b011000;
  localparam logic [OpW-1:0] OpSlt  = 6'b100110;
  localparam logic [OpW-1:0] OpSw   = 6'b110000;
  localparam logic [OpW-1:0] OpLw   = 6'b110001;
  localparam logic [OpW-1:0] OpBeq  = 6'b110100;
  localparam logic [OpW-1:0] OpJ    = 6'b111000;
  localparam logic [OpW-1:0] OpJr   = 6'b111001;
  localparam logic [OpW-1:0] OpJal  = 6'b111010;
  localparam logic [OpW-1:0] OpHalt = 6'b111111;

  localparam logic [AluW-1:0] AluAdd = 3'b000;
  localparam logic [AluW-1:0] AluSub = 3'b001;
  localparam logic [AluW-1:0] AluSlt = 3'b010;
  localparam logic [AluW-1:0] AluSll = 3'b100;
  localparam logic [AluW-1:0] AluOr  = 3'b101;
  localparam logic [AluW-1:0] AluAnd = 3'b110;
  localparam logic [AluW-1:0] AluXor = 3'b111;

  localparam logic [1:0] PcNext   = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcReg    = 2'b10;
  localparam logic [1:0] PcJump   = 2'b11;

  localparam logic [1:0] DstRa = 2'b00;
  localparam logic [1:0] DstRt = 2'b01;
  localparam logic [1:0] DstRd = 2'b10;

  typedef enum logic [StateW-1:0] {
    sIF     = 3'b000,
    sID     = 3'b001,
    sEXE_LS = 3'b010,
    sMEM    = 3'b011,
    sWB_LD  = 3'b100,
    sEXE_BR = 3'b101,
    sEXE_AL = 3'b110,
    sWB_AL  = 3'b111
  } stateT;

  stateT curState;
  stateT nextState;

  logic            isAluOp;
  logic            isImmAlu;
  logic            isMemOp;
  logic            isJumpOp;
  logic            isIllegal;
  logic [AluW-1:0] aluOpSel;

  // State register; reset forces fetch immediately.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) curState <= sIF;
    else        curState <= nextState;
  end

  // Opcode classification.
  always_comb begin
    isAluOp   = 1'b0;
    isImmAlu  = 1'b0;
    isMemOp   = 1'b0;
    isJumpOp  = 1'b0;
    isIllegal = 1'b0;
    aluOpSel  = AluAdd;
    case (opcode)
      OpAdd:  begin isAluOp = 1'b1; aluOpSel = AluAdd; end
      OpSub:  begin isAluOp = 1'b1; aluOpSel = AluSub; end
      OpAddi: begin isAluOp = 1'b1; isImmAlu = 1'b1; aluOpSel = AluAdd; end
      OpOr:   begin isAluOp = 1'b1; aluOpSel = AluOr; end
      OpAnd:  begin isAluOp = 1'b1; aluOpSel = AluAnd; end
      OpOri:  begin isAluOp = 1'b1; isImmAlu = 1'b1; aluOpSel = AluOr; end
      OpSll:  begin isAluOp = 1'b1; aluOpSel = AluSll; end
      OpSlt:  begin isAluOp = 1'b1; aluOpSel = AluSlt; end
      OpSw, OpLw:      isMemOp  = 1'b1;
      OpJ, OpJr, OpJal: isJumpOp = 1'b1;
      OpBeq, OpHalt:   ;
      default:         isIllegal = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    nextState = curState;
    case (curState)
      sIF: nextState = sID;
      sID: begin
        if (isJumpOp || isIllegal) nextState = sIF;
        else if (opcode == OpHalt) nextState = sID;
        else if (opcode == OpBeq)  nextState = sEXE_BR;
        else if (isMemOp)          nextState = sEXE_LS;
        else                       nextState = sEXE_AL;
      end
      sEXE_AL: nextState = sWB_AL;
      sWB_AL:  nextState = sIF;
      sEXE_BR: nextState = sIF;
      sEXE_LS: nextState = sMEM;
      sMEM:    nextState = (opcode == OpLw) ? sWB_LD : sIF;
      sWB_LD:  nextState = sIF;
      default: nextState = sIF;
    endcase
  end

  // Control decode; every output defaults to 0 and each state raises its own.
  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PcNext;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = AluAdd;
    RegWre    = 1'b0;
    RegDst    = DstRa;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    case (curState)
      sIF: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      sID: begin
        ExtSel = (opcode != OpOri);
        case (opcode)
          OpJ: begin
            PCWre = 1'b1;
            PCSrc = PcJump;
          end
          OpJr: begin
            PCWre = 1'b1;
            PCSrc = PcReg;
          end
          OpJal: begin
            PCWre     = 1'b1;
            PCSrc     = PcJump;
            RegWre    = 1'b1;
            RegDst    = DstRa;
            WrRegDSrc = 1'b0;
          end
          default: begin
            // Unknown opcodes retire as a nop with a plain PC+4 step.
            if (isIllegal) begin
              PCWre = 1'b1;
              PCSrc = PcNext;
            end
          end
        endcase
      end
      sEXE_AL, sWB_AL: begin
        // ALU operand/operation controls stay stable across execute and write-back.
        ALUOp   = aluOpSel;
        ALUSrcA = (opcode == OpSll);
        ALUSrcB = isImmAlu;
        ExtSel  = (opcode != OpOri);
        if (curState == sWB_AL) begin
          RegWre    = 1'b1;
          WrRegDSrc = 1'b1;
          DBDataSrc = 1'b0;
          RegDst    = isImmAlu ? DstRt : DstRd;
          PCWre     = 1'b1;
          PCSrc     = PcNext;
        end
      end
      sEXE_BR: begin
        ALUOp   = AluXor;
        ALUSrcB = 1'b0;
        PCWre   = 1'b1;
        PCSrc   = zero ? PcBranch : PcNext;
      end
      sEXE_LS, sMEM: begin
        // Address computation held through the memory access.
        ALUOp   = AluAdd;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if (curState == sMEM) begin
          if (opcode == OpLw) begin
            mRD = 1'b1;
          end else begin
            mWR   = 1'b1;
            PCWre = 1'b1;
            PCSrc = PcNext;
          end
        end
      end
      sWB_LD: begin
        mRD       = 1'b1;
        RegWre    = 1'b1;
        RegDst    = DstRt;
        WrRegDSrc = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
        PCSrc     = PcNext;
      end
      default: ;
    endcase
  end

  assign state = curState;

endmodule
